// File: rtl/key_scan_module.sv
// key_scan_module: per-key two-flop synchronizer, debounce filter and press/hold/repeat pulse FSM.
// Define KEY_AUTO_REPEAT_EN to build the HELD/REPEAT auto-repeat path; otherwise one pulse per press.
module key_scan_module #(
    parameter int N_KEYS       = 3,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [N_KEYS-1:0] Key_In,
    output logic [N_KEYS-1:0] Key_Level,
    output logic [N_KEYS-1:0] Key_Pulse,
    output logic [N_KEYS-1:0] Key_Release
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

`ifdef KEY_AUTO_REPEAT_EN
    localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int                REP_W     = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} keyState_t;
`else
    typedef enum logic {IDLE, PRESSED} keyState_t;
`endif

    if (DEBOUNCE_CYC < 2 || HOLD_CYC < 1 || REPEAT_CYC < 1) begin : gBadParams
        $error("key_scan_module: need DEBOUNCE_CYC >= 2, HOLD_CYC >= 1, REPEAT_CYC >= 1");
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : gKey
        logic            sync1;
        logic            sync2;
        logic            stablePressed;
        logic [DB_W-1:0] dbCnt;
        keyState_t       state;
        keyState_t       stateNext;
        logic            keyLevel;
        logic            keyPulse;
        logic            keyRelease;
        logic            levelNext;
        logic            pulseNext;
        logic            releaseNext;

        // Raw keys are active-low; the stable state is kept as "pressed".
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                sync1         <= 1'b1;
                sync2         <= 1'b1;
                stablePressed <= 1'b0;
                dbCnt         <= '0;
            end else begin
                sync1 <= Key_In[k];
                sync2 <= sync1;
                if (~sync2 == stablePressed) begin
                    dbCnt <= '0;
                end else if (dbCnt == DB_LAST) begin
                    stablePressed <= ~stablePressed;
                    dbCnt         <= '0;
                end else begin
                    dbCnt <= dbCnt + 1'b1;
                end
            end
        end

        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                state      <= IDLE;
                keyLevel   <= 1'b0;
                keyPulse   <= 1'b0;
                keyRelease <= 1'b0;
            end else begin
                state      <= stateNext;
                keyLevel   <= levelNext;
                keyPulse   <= pulseNext;
                keyRelease <= releaseNext;
            end
        end

`ifdef KEY_AUTO_REPEAT_EN
        logic [HOLD_W-1:0] holdCnt;
        logic [REP_W-1:0]  repCnt;
        logic              holdDone;
        logic              repDone;

        assign holdDone = (holdCnt == HOLD_LAST);
        assign repDone  = (repCnt == REP_LAST);

        // Counters run only while the FSM stays in their state, so any exit or release clears them.
        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                holdCnt <= '0;
                repCnt  <= '0;
            end else begin
                if (state != HELD || stateNext != HELD) begin
                    holdCnt <= '0;
                end else if (!holdDone) begin
                    holdCnt <= holdCnt + 1'b1;
                end
                if (state != REPEAT || stateNext != REPEAT || repDone) begin
                    repCnt <= '0;
                end else begin
                    repCnt <= repCnt + 1'b1;
                end
            end
        end

        // NOTE: every combinational output gets a default first so no latch is inferred.
        always_comb begin
            stateNext = state;
            case (state)
                IDLE:    if (stablePressed) stateNext = HELD;
                HELD:    if (!stablePressed) stateNext = IDLE;
                         else if (holdDone) stateNext = REPEAT;
                REPEAT:  if (!stablePressed) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end

        // A release on a tick edge suppresses the tick because every pulse requires stablePressed.
        always_comb begin
            levelNext   = (stateNext != IDLE);
            releaseNext = (state != IDLE) && !stablePressed;
            pulseNext   = 1'b0;
            if (stablePressed) begin
                case (state)
                    IDLE:    pulseNext = 1'b1;
                    HELD:    pulseNext = holdDone;
                    REPEAT:  pulseNext = repDone;
                    default: pulseNext = 1'b0;
                endcase
            end
        end
`else
        always_comb begin
            stateNext = stablePressed ? PRESSED : IDLE;
        end

        always_comb begin
            levelNext   = (stateNext == PRESSED);
            pulseNext   = (state == IDLE) && stablePressed;
            releaseNext = (state == PRESSED) && !stablePressed;
        end
`endif

        assign Key_Level[k]   = keyLevel;
        assign Key_Pulse[k]   = keyPulse;
        assign Key_Release[k] = keyRelease;
    end

endmodule

// File: tb/tb_key_scan_module.sv
// Self-checking bench for key_scan_module: directed scenarios plus random key activity,
// compared every cycle against a run-length / press-age reference model.
module tb_key_scan_module;

    localparam int N_KEYS       = 3;
    localparam int DEBOUNCE_CYC = 4;
    localparam int HOLD_CYC     = 20;
    localparam int REPEAT_CYC   = 8;

`ifdef KEY_AUTO_REPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RSTn;
    logic [N_KEYS-1:0] Key_In;
    logic [N_KEYS-1:0] Key_Level;
    logic [N_KEYS-1:0] Key_Pulse;
    logic [N_KEYS-1:0] Key_Release;

    int checks = 0;
    int errors = 0;

    // Reference model: input history, accepted level, mismatch run length, age of current press.
    logic [N_KEYS-1:0] inHist[$];
    logic [N_KEYS-1:0] modStable;
    logic [N_KEYS-1:0] expLevel;
    logic [N_KEYS-1:0] expPulse;
    logic [N_KEYS-1:0] expRelease;
    int                modRun[N_KEYS];
    int                pressAge[N_KEYS];

    key_scan_module #(
        .N_KEYS      (N_KEYS),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .REPEAT_CYC  (REPEAT_CYC)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Key_In     (Key_In),
        .Key_Level  (Key_Level),
        .Key_Pulse  (Key_Pulse),
        .Key_Release(Key_Release)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        inHist = {};
        inHist.push_back('1);
        inHist.push_back('1);
        modStable  = '0;
        expLevel   = '0;
        expPulse   = '0;
        expRelease = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            modRun[k]   = 0;
            pressAge[k] = 0;
        end
    endtask

    // Advance one rising edge; the debouncer sees the raw level from two edges earlier,
    // and the outputs on this edge reflect the level accepted on the previous edge.
    task automatic step();
        logic [N_KEYS-1:0] seen;
        @(posedge CLK);
        inHist.push_back(Key_In);
        seen = inHist.pop_front();
        for (int k = 0; k < N_KEYS; k++) begin
            expPulse[k]   = 1'b0;
            expRelease[k] = 1'b0;
            if (modStable[k] && !expLevel[k]) begin
                expPulse[k] = 1'b1;
                pressAge[k] = 0;
            end else if (modStable[k]) begin
                pressAge[k]++;
                if (AUTO_REPEAT && pressAge[k] >= HOLD_CYC &&
                    (pressAge[k] - HOLD_CYC) % REPEAT_CYC == 0)
                    expPulse[k] = 1'b1;
            end else if (expLevel[k]) begin
                expRelease[k] = 1'b1;
            end
            expLevel[k] = modStable[k];
            if ((!seen[k]) != modStable[k]) begin
                modRun[k]++;
                if (modRun[k] == DEBOUNCE_CYC) begin
                    modStable[k] = ~modStable[k];
                    modRun[k]    = 0;
                end
            end else begin
                modRun[k] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        RSTn   = 1'b0;
        Key_In = '0;
        #17;
        checks++;
        if ({Key_Level, Key_Pulse, Key_Release} !== '0) begin
            errors++;
            $display("FAIL reset_state: level/pulse/release %b/%b/%b, want all 0",
                     Key_Level, Key_Pulse, Key_Release);
        end
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({Key_Level, Key_Pulse, Key_Release} !== '0) begin
            errors++;
            $display("FAIL reset_hold_pressed: level/pulse/release %b/%b/%b, want all 0",
                     Key_Level, Key_Pulse, Key_Release);
        end
        Key_In = '1;
        RSTn   = 1'b1;
        model_reset();
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if ({Key_Level, Key_Pulse, Key_Release} !== {expLevel, expPulse, expRelease}) begin
                errors++;
                $display("FAIL reset_idle edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         Key_Level, Key_Pulse, Key_Release, expLevel, expPulse, expRelease);
            end
        end
    endtask

    task automatic test_clean_press();
        int firstPulse = -1;
        int nPulse     = 0;
        int relEdge    = -1;
        for (int e = 0; e < 30; e++) begin
            Key_In = (e < 12) ? 3'b110 : 3'b111;
            step();
            if (Key_Pulse[0]) begin
                nPulse++;
                if (firstPulse < 0) firstPulse = e;
            end
            if (Key_Release[0] && relEdge < 0) relEdge = e;
            checks++;
            if ({Key_Level, Key_Pulse, Key_Release} !== {expLevel, expPulse, expRelease}) begin
                errors++;
                $display("FAIL clean_press edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         Key_Level, Key_Pulse, Key_Release, expLevel, expPulse, expRelease);
            end
        end
        checks++;
        if (firstPulse != 6 || nPulse != 1) begin
            errors++;
            $display("FAIL clean_press_pulse: first edge %0d count %0d, want edge 6 count 1",
                     firstPulse, nPulse);
        end
        checks++;
        if (relEdge != 18) begin
            errors++;
            $display("FAIL clean_press_release: edge %0d, want 18", relEdge);
        end
    endtask

    task automatic test_bounce();
        for (int e = 0; e < 30; e++) begin
            Key_In    = '1;
            Key_In[1] = (e < 20) ? ((e / 2) % 2 == 1) : 1'b1;
            step();
            checks++;
            if ({Key_Level[1], Key_Pulse[1], Key_Release[1]} !== 3'b000) begin
                errors++;
                $display("FAIL bounce edge %0d: key1 level/pulse/release %b%b%b, want 000", e,
                         Key_Level[1], Key_Pulse[1], Key_Release[1]);
            end
            checks++;
            if ({Key_Level, Key_Pulse, Key_Release} !== {expLevel, expPulse, expRelease}) begin
                errors++;
                $display("FAIL bounce_model edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         Key_Level, Key_Pulse, Key_Release, expLevel, expPulse, expRelease);
            end
        end
    endtask

    task automatic test_hold();
        int pulses[$];
        int want[$];
        int relEdge = -1;
        if (AUTO_REPEAT) want = {6, 26, 34, 42, 50, 58};
        else             want = {6};
        for (int e = 0; e < 76; e++) begin
            Key_In = (e < 60) ? 3'b011 : 3'b111;
            step();
            if (Key_Pulse[2]) pulses.push_back(e);
            if (Key_Release[2] && relEdge < 0) relEdge = e;
            checks++;
            if ({Key_Level, Key_Pulse, Key_Release} !== {expLevel, expPulse, expRelease}) begin
                errors++;
                $display("FAIL hold edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         Key_Level, Key_Pulse, Key_Release, expLevel, expPulse, expRelease);
            end
        end
        checks++;
        if (pulses.size() != want.size()) begin
            errors++;
            $display("FAIL hold_pulse_count: %0d pulses, want %0d", pulses.size(), want.size());
        end else begin
            foreach (want[i]) begin
                checks++;
                if (pulses[i] != want[i]) begin
                    errors++;
                    $display("FAIL hold_pulse_edge %0d: edge %0d, want %0d", i, pulses[i], want[i]);
                end
            end
        end
        checks++;
        if (relEdge != 66) begin
            errors++;
            $display("FAIL hold_release: edge %0d, want 66", relEdge);
        end
    endtask

    task automatic test_release_on_tick();
        for (int e = 0; e < 50; e++) begin
            Key_In = (e < 36) ? 3'b110 : 3'b111;
            step();
            if (e == 42) begin
                checks++;
                if (Key_Release[0] !== 1'b1 || Key_Pulse[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL release_on_tick: release %b pulse %b, want 1 0",
                             Key_Release[0], Key_Pulse[0]);
                end
            end
            checks++;
            if ({Key_Level, Key_Pulse, Key_Release} !== {expLevel, expPulse, expRelease}) begin
                errors++;
                $display("FAIL release_tick_model edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         Key_Level, Key_Pulse, Key_Release, expLevel, expPulse, expRelease);
            end
        end
    endtask

    task automatic test_all_keys();
        for (int e = 0; e < 54; e++) begin
            Key_In = (e < 40) ? 3'b000 : 3'b111;
            step();
            checks++;
            if ((Key_Pulse != 3'b000 && Key_Pulse != 3'b111) ||
                (Key_Level != 3'b000 && Key_Level != 3'b111)) begin
                errors++;
                $display("FAIL all_keys_match edge %0d: pulse %b level %b, want identical bits",
                         e, Key_Pulse, Key_Level);
            end
            checks++;
            if ({Key_Level, Key_Pulse, Key_Release} !== {expLevel, expPulse, expRelease}) begin
                errors++;
                $display("FAIL all_keys edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         Key_Level, Key_Pulse, Key_Release, expLevel, expPulse, expRelease);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int firstPulse = -1;
        int nPulse     = 0;
        int nRel       = 0;
        for (int e = 0; e < 40; e++) begin
            Key_In = 3'b110;
            step();
            checks++;
            if ({Key_Level, Key_Pulse, Key_Release} !== {expLevel, expPulse, expRelease}) begin
                errors++;
                $display("FAIL pre_reset edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         Key_Level, Key_Pulse, Key_Release, expLevel, expPulse, expRelease);
            end
        end
        #3;
        RSTn = 1'b0;
        #1;
        checks++;
        if ({Key_Level, Key_Pulse, Key_Release} !== '0) begin
            errors++;
            $display("FAIL reset_async_drop: level/pulse/release %b/%b/%b, want all 0",
                     Key_Level, Key_Pulse, Key_Release);
        end
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        model_reset();
        for (int e = 0; e < 20; e++) begin
            Key_In = 3'b110;
            step();
            if (Key_Pulse[0]) begin
                nPulse++;
                if (firstPulse < 0) firstPulse = e;
            end
            if (Key_Release[0]) nRel++;
            checks++;
            if ({Key_Level, Key_Pulse, Key_Release} !== {expLevel, expPulse, expRelease}) begin
                errors++;
                $display("FAIL post_reset edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         Key_Level, Key_Pulse, Key_Release, expLevel, expPulse, expRelease);
            end
        end
        checks++;
        if (firstPulse != 6 || nPulse != 1 || nRel != 0) begin
            errors++;
            $display("FAIL reset_repress: pulse edge %0d count %0d releases %0d, want 6 1 0",
                     firstPulse, nPulse, nRel);
        end
        for (int e = 0; e < 15; e++) begin
            Key_In = 3'b111;
            step();
            checks++;
            if ({Key_Level, Key_Pulse, Key_Release} !== {expLevel, expPulse, expRelease}) begin
                errors++;
                $display("FAIL post_reset_release edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         Key_Level, Key_Pulse, Key_Release, expLevel, expPulse, expRelease);
            end
        end
    endtask

    task automatic test_random();
        int                dur[N_KEYS];
        logic [N_KEYS-1:0] lvl;
        lvl = '1;
        for (int k = 0; k < N_KEYS; k++) dur[k] = $urandom_range(1, 30);
        for (int e = 0; e < 1600; e++) begin
            for (int k = 0; k < N_KEYS; k++) begin
                if (dur[k] == 0) begin
                    lvl[k] = ~lvl[k];
                    dur[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                          : int'($urandom_range(5, 60));
                end
                dur[k]--;
            end
            Key_In = (e < 1580) ? lvl : 3'b111;
            step();
            checks++;
            if ({Key_Level, Key_Pulse, Key_Release} !== {expLevel, expPulse, expRelease}) begin
                errors++;
                $display("FAIL random edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         Key_Level, Key_Pulse, Key_Release, expLevel, expPulse, expRelease);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold();
        test_release_on_tick();
        test_all_keys();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_scan_module.md
# key_scan_module

Input-side front end for the digital clock: conditions raw, bouncy board keys into clean, single-cycle command pulses. These pulses drive the time-adjust and display-select inputs of the timekeeping and display logic. Each key gets three stages:
- a two-flop synchronizer;
- a debounce counter;
- a press/hold/auto-repeat state machine, so holding an adjust key advances the value repeatedly.

## Interface
- N_KEYS, 3, number of independent keys.
- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); must be ≥2.
- HOLD_CYC, 50_000_000, cycles a key must stay pressed before auto-repeat starts (1 s); must be ≥1.
- REPEAT_CYC, 10_000_000, auto-repeat period in cycles (200 ms); must be ≥1.
- CLK  input  1  system clock, all logic on rising edge.
- RSTn  input  1  asynchronous active-low reset.
- Key_In  input  N_KEYS  raw key levels, active-low (0 = pressed), asynchronous to CLK.
- Key_Level  output  N_KEYS  debounced level, 1 = pressed.
- Key_Pulse  output  N_KEYS  one-cycle pulse on accepted press and on each auto-repeat tick.
- Key_Release  output  N_KEYS  one-cycle pulse on accepted release.

## Operation
- Keys are fully independent. Per-key logic is replicated; there is no cross-key arbitration.
- Synchronizer: Key_In[i] goes to s1, then to s2. The debounce stage uses only s2.
- Debounce: the stable state is kept internally, starting as released.
  - While s2 differs from the stable state, the counter increments.
  - When s2 equals the stable state, the counter clears to 0.
  - A mismatch that is present on the edge where the counter equals DEBOUNCE_CYC-1 toggles the stable state and clears the counter.
  - Glitches shorter than DEBOUNCE_CYC cycles produce no output.
- The FSM has three states: IDLE, HELD and REPEAT.
  - IDLE: on the stable press transition, go to HELD, set Key_Level = 1, pulse Key_Pulse, and clear the hold counter.
  - HELD: the hold counter counts cycles. When the count reaches HOLD_CYC, pulse Key_Pulse, go to REPEAT, and clear the repeat counter.
  - REPEAT: pulse Key_Pulse every REPEAT_CYC cycles.
  - Any state, on the stable release transition: clear Key_Level, pulse Key_Release, go to IDLE, and clear all counters.
- If release and a hold or repeat tick fall on the same edge, release wins: no Key_Pulse on that edge.
- Counter widths are $clog2 of the largest count each counter reaches. Counters saturate and never wrap.

## Timing
- Reset values: Key_Level = 0, Key_Pulse = 0 and Key_Release = 0. Synchronizer flops reset to 1, the stable state to released, counters to 0, and the FSM to IDLE.
- Reset mid-press:
  - Reset returns the block to IDLE with no Key_Release pulse.
  - A key still held after RSTn deasserts counts as a fresh press, accepted after the full debounce latency.
- Press latency: when Key_In falls before edge 0 and stays low, Key_Level rises and Key_Pulse asserts on edge DEBOUNCE_CYC+2. Release latency is identical.
- First repeat pulse: HOLD_CYC edges after the press pulse. Later repeat pulses follow at REPEAT_CYC spacing.
- Every output is registered. Pulses are exactly one cycle wide, and Key_Pulse and Key_Release never assert together for the same key.

## Configuration
- KEY_AUTO_REPEAT_EN defined: full IDLE/HELD/REPEAT behaviour as above.
- KEY_AUTO_REPEAT_EN undefined:
  - The HELD and REPEAT states and their counters are not built.
  - Key_Pulse fires only once per accepted press.
  - HOLD_CYC and REPEAT_CYC are ignored.

## Test plan
All scenarios use DEBOUNCE_CYC = 4, HOLD_CYC = 20, REPEAT_CYC = 8, N_KEYS = 3, with KEY_AUTO_REPEAT_EN defined unless stated otherwise.
- Clean press: Key_In[0] drops to 0 before edge 0 and is held 12 cycles → Key_Level[0] rises and Key_Pulse[0] fires on edge 6. Key_Release[0] fires 6 edges after Key_In returns to 1. No repeat pulses.
- Bounce: Key_In[1] toggles every 2 cycles for 20 cycles, then stays at 1 → Key_Level, Key_Pulse and Key_Release stay 0 throughout.
- Hold: Key_In[2] is held low for 60 cycles → Key_Pulse[2] fires on edges 6, 26, 34, 42, 50, 58. Key_Release[2] fires 6 edges after release.
- Simultaneous events:
  - Release timed so the stable release lands on a repeat-tick edge → Key_Release asserts and Key_Pulse stays 0 on that edge.
  - All three keys pressed on the same cycle → three identical, independent pulse trains.
- Reset mid-hold: RSTn is asserted during REPEAT while the key stays low → all outputs drop to 0 immediately. After deassertion, a new Key_Pulse arrives on edge 6 with no Key_Release.
- Macro off: rerun the hold scenario with KEY_AUTO_REPEAT_EN undefined → exactly one Key_Pulse, on edge 6.
